ula_seq: RTL

ULA_SEQ -- requirements
Module: ula_seq

---
 rtl/ula_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ula_seq.sv
// Sequential ALU: latches operands on a start request, iterates multi-cycle ops
// (shift-add multiply, bit-serial shift left), then writes the result back in one cycle.
//
// state   | meaning
// OCIOSO  | idle, waiting for inicio
// CALC    | computing; lasts k cycles set by the latched op
// ESCRITA | one-cycle writeback / completion pulse
module ula_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        inicio,
    input  logic [2:0]  op,
    input  logic [1:0]  reg_dst,
    input  logic [31:0] dado_l_1,
    input  logic [31:0] dado_l_2,
    output logic        ocupado,
    output logic        pronto,
    output logic        e_l,
    output logic [1:0]  reg_e,
    output logic [31:0] dado,
    output logic        zero
);

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] CALC    = 2'd1;
    localparam logic [1:0] ESCRITA = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [2:0]  op_r;
    logic [1:0]  dst_r;
    logic [31:0] a_r, b_r, acc;
    logic [31:0] a_nxt, b_nxt, acc_nxt, res;
    logic [4:0]  cnt_load;

    // One iteration step; res is the value written to dado on the last CALC cycle.
    always_comb begin
        a_nxt   = a_r;
        b_nxt   = b_r;
        acc_nxt = acc;
        res     = dado;
        case (op_r)
            OP_ADD: res = a_r + b_r;
            OP_SUB: res = a_r - b_r;
            OP_AND: res = a_r & b_r;
            OP_OR:  res = a_r | b_r;
            OP_SLT: res = {31'd0, ($signed(a_r) < $signed(b_r))};
            OP_MUL: begin
                acc_nxt = acc + (b_r[0] ? a_r : 32'd0);
                a_nxt   = a_r << 1;
                b_nxt   = b_r >> 1;
                res     = acc_nxt;
            end
            OP_SLL: begin
                if (b_r[4:0] != 5'd0)
                    acc_nxt = acc << 1;
                res = acc_nxt;
            end
            default: res = dado;
        endcase
    end

    // Down-counter preload is k-1 so the terminal count (0) marks the final CALC cycle.
    always_comb begin
        cnt_load = 5'd0;
        if (op == OP_MUL)
            cnt_load = 5'd31;
        else if (op == OP_SLL && dado_l_2[4:0] != 5'd0)
            cnt_load = dado_l_2[4:0] - 5'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OCIOSO;
            cnt   <= 5'd0;
            op_r  <= 3'd0;
            dst_r <= 2'd0;
            a_r   <= 32'd0;
            b_r   <= 32'd0;
            acc   <= 32'd0;
            reg_e <= 2'd0;
            dado  <= 32'd0;
        end else begin
            case (state)
                OCIOSO: begin
                    if (inicio) begin
                        state <= CALC;
                        op_r  <= op;
                        dst_r <= reg_dst;
                        a_r   <= dado_l_1;
                        b_r   <= dado_l_2;
                        cnt   <= cnt_load;
                        acc   <= (op == OP_SLL) ? dado_l_1 : 32'd0;
                    end
                end
                CALC: begin
                    a_r <= a_nxt;
                    b_r <= b_nxt;
                    acc <= acc_nxt;
                    if (cnt == 5'd0) begin
                        state <= ESCRITA;
                        reg_e <= dst_r;
                        if (op_r != OP_RSV)
                            dado <= res;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                ESCRITA: state <= OCIOSO;
                default: state <= OCIOSO;
            endcase
        end
    end

    assign ocupado = (state == CALC) || (state == ESCRITA);
    assign pronto  = (state == ESCRITA);
    assign e_l     = (state == ESCRITA) && (op_r != OP_RSV);
    assign zero    = (dado == 32'd0);

endmodule
